mem_stage_ws: RTL and testbench

Parametrised successor to the processor's memory-cycle stage: data-memory word access with configurable wait states and a stall handshake back to the pipeline.
- Multi-channel memory-mapped I/O.
- ALU-result forwarding register.
- Sits between execute and write-back; write-back consumes memout/alufor when valid_out is high.

---
 rtl/mem_stage_ws.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_stage_ws.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ws.sv
// Memory-cycle pipeline stage: data-memory word access with WAIT_STATES stall cycles,
// memory-mapped I/O channels and ALU-result forwarding. Optional counters: MEM_STAGE_PERF_EN.
module mem_stage_ws #(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DEPTH_LOG2  = 10,
  parameter int unsigned       WAIT_STATES = 2,
  parameter int unsigned       IO_CH       = 2,
  parameter logic [ADDR_W-1:0] IO_BASE     = ADDR_W'(16'hFFF0)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic                    memread,
  input  logic                    memwrite,
  input  logic [DATA_W-1:0]       b,
  input  logic [ADDR_W-1:0]       aluout,
  input  logic [IO_CH*DATA_W-1:0] read_in,
  output logic [IO_CH*DATA_W-1:0] write_out,
  output logic [IO_CH-1:0]        write_strobe,
  output logic [DATA_W-1:0]       memout,
  output logic [DATA_W-1:0]       alufor,
  output logic                    valid_out,
  output logic                    stall
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CH_W  = 4;
  localparam bit          HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = HAS_WAIT ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]       lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]       lat_b_q, lat_b_d;
  logic                    lat_rd_q, lat_rd_d;
  logic                    lat_wr_q, lat_wr_d;
  logic [IO_CH*DATA_W-1:0] write_out_q, write_out_d;
  logic [IO_CH-1:0]        write_strobe_q, write_strobe_d;
  logic [DATA_W-1:0]       memout_q, memout_d;
  logic [DATA_W-1:0]       alufor_q, alufor_d;
  logic                    valid_q, valid_d;

  logic [DATA_W-1:0]       mem_q [DEPTH];

  logic                    in_wait_c;
  logic [ADDR_W-1:0]       eff_addr_c;
  logic [DATA_W-1:0]       eff_b_c;
  logic                    eff_rd_c;
  logic                    eff_wr_c;
  logic                    io_c;
  logic [CH_W-1:0]         ch_c;
  logic [DEPTH_LOG2-1:0]   idx_c;
  logic                    mem_op_c;
  logic                    stall_c;
  logic                    complete_c;
  logic                    mem_we_c;
  logic [DATA_W-1:0]       io_rd_c;

`ifdef MEM_STAGE_PERF_EN
  logic [DATA_W-1:0]       acc_cnt_q, acc_cnt_d;
  logic [DATA_W-1:0]       stall_cnt_q, stall_cnt_d;
`endif

  // In WAIT the latched copies drive the datapath; in IDLE the live inputs do.
  always_comb begin
    in_wait_c  = (state_q == ST_WAIT);
    eff_addr_c = in_wait_c ? lat_addr_q : aluout;
    eff_b_c    = in_wait_c ? lat_b_q    : b;
    eff_rd_c   = in_wait_c ? lat_rd_q   : memread;
    eff_wr_c   = in_wait_c ? lat_wr_q   : memwrite;
    io_c       = (eff_addr_c[ADDR_W-1:CH_W] == IO_BASE[ADDR_W-1:CH_W]);
    ch_c       = eff_addr_c[CH_W-1:0];
    idx_c      = eff_addr_c[DEPTH_LOG2-1:0];
    mem_op_c   = (eff_rd_c || eff_wr_c) && !io_c;
  end

  // I/O read mux; unpopulated channels read as zero unless they map a counter.
  always_comb begin
    io_rd_c = '0;
    for (int i = 0; i < int'(IO_CH); i++) begin
      if (ch_c == CH_W'(i)) io_rd_c = read_in[i*DATA_W +: DATA_W];
    end
`ifdef MEM_STAGE_PERF_EN
    if (ch_c == CH_W'(14)) io_rd_c = acc_cnt_q;
    if (ch_c == CH_W'(15)) io_rd_c = stall_cnt_q;
`endif
  end

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lat_addr_d     = lat_addr_q;
    lat_b_d        = lat_b_q;
    lat_rd_d       = lat_rd_q;
    lat_wr_d       = lat_wr_q;
    write_out_d    = write_out_q;
    write_strobe_d = '0;
    memout_d       = memout_q;
    alufor_d       = alufor_q;
    valid_d        = 1'b0;
    stall_c        = 1'b0;
    complete_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Gating with rst keeps stall low and blocks any commit while reset is held.
        if (valid_in && rst) begin
          if (HAS_WAIT && mem_op_c) begin
            stall_c    = 1'b1;
            state_d    = ST_WAIT;
            cnt_d      = CNT_LOAD;
            lat_addr_d = aluout;
            lat_b_d    = b;
            lat_rd_d   = memread;
            lat_wr_d   = memwrite;
          end else begin
            complete_c = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        stall_c = (cnt_q != '0);
        if (cnt_q == '0) begin
          complete_c = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete_c) begin
      valid_d  = 1'b1;
      alufor_d = DATA_W'(eff_addr_c);
      if (eff_wr_c) begin
        if (io_c) begin
          for (int i = 0; i < int'(IO_CH); i++) begin
            if (ch_c == CH_W'(i)) begin
              write_out_d[i*DATA_W +: DATA_W] = eff_b_c;
              write_strobe_d[i]               = 1'b1;
            end
          end
        end
      end else if (eff_rd_c) begin
        memout_d = io_c ? io_rd_c : mem_q[idx_c];
      end
    end
  end

  assign mem_we_c = complete_c && eff_wr_c && !io_c;

`ifdef MEM_STAGE_PERF_EN
  // Saturating access and stall-cycle counters; I/O stores to ch14/15 clear them.
  always_comb begin
    acc_cnt_d   = acc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (complete_c && io_c && eff_wr_c && ch_c == CH_W'(14)) begin
      acc_cnt_d = '0;
    end else if (complete_c && mem_op_c && acc_cnt_q != '1) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
    if (complete_c && io_c && eff_wr_c && ch_c == CH_W'(15)) begin
      stall_cnt_d = '0;
    end else if (stall_c && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      acc_cnt_q   <= acc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      lat_addr_q     <= '0;
      lat_b_q        <= '0;
      lat_rd_q       <= 1'b0;
      lat_wr_q       <= 1'b0;
      write_out_q    <= '0;
      write_strobe_q <= '0;
      memout_q       <= '0;
      alufor_q       <= '0;
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lat_addr_q     <= lat_addr_d;
      lat_b_q        <= lat_b_d;
      lat_rd_q       <= lat_rd_d;
      lat_wr_q       <= lat_wr_d;
      write_out_q    <= write_out_d;
      write_strobe_q <= write_strobe_d;
      memout_q       <= memout_d;
      alufor_q       <= alufor_d;
      valid_q        <= valid_d;
    end
  end

  // Data array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[idx_c] <= eff_b_c;
  end

  assign write_out    = write_out_q;
  assign write_strobe = write_strobe_q;
  assign memout       = memout_q;
  assign alufor       = alufor_q;
  assign valid_out    = valid_q;
  assign stall        = stall_c;

endmodule

// File: tb/tb_mem_stage_ws.sv
// Self-checking bench for mem_stage_ws: transaction-level reference model plus directed
// literal checks and a randomized phase. Covers the MEM_STAGE_PERF_EN counters when defined.
module tb_mem_stage_ws;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH_LOG2 = 10;
  localparam int unsigned WS = 2;
  localparam int unsigned IO_CH = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    valid_in = 1'b0;
  logic                    memread = 1'b0;
  logic                    memwrite = 1'b0;
  logic [DATA_W-1:0]       b = '0;
  logic [ADDR_W-1:0]       aluout = '0;
  logic [IO_CH*DATA_W-1:0] read_in = '0;
  logic [IO_CH*DATA_W-1:0] write_out;
  logic [IO_CH-1:0]        write_strobe;
  logic [DATA_W-1:0]       memout;
  logic [DATA_W-1:0]       alufor;
  logic                    valid_out;
  logic                    stall;

  mem_stage_ws #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2),
    .WAIT_STATES(WS), .IO_CH(IO_CH), .IO_BASE(16'hFFF0)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .memread(memread), .memwrite(memwrite),
    .b(b), .aluout(aluout), .read_in(read_in), .write_out(write_out),
    .write_strobe(write_strobe), .memout(memout), .alufor(alufor),
    .valid_out(valid_out), .stall(stall)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DATA_W-1:0]       m_mem [1024];
  logic [DATA_W-1:0]       m_wo [IO_CH];
`ifdef MEM_STAGE_PERF_EN
  int                      m_acc;
  int                      m_stl;
`endif
  logic                    exp_stall, exp_valid;
  logic [IO_CH-1:0]        exp_strobe;
  logic [DATA_W-1:0]       exp_memout, exp_alufor;
  logic [IO_CH*DATA_W-1:0] exp_wo;

  int checks = 0;
  int errors = 0;
  int stall_seen = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall", 64'(stall), 64'(exp_stall));
      chk("valid_out", 64'(valid_out), 64'(exp_valid));
      chk("write_strobe", 64'(write_strobe), 64'(exp_strobe));
      chk("memout", 64'(memout), 64'(exp_memout));
      chk("alufor", 64'(alufor), 64'(exp_alufor));
      chk("write_out", 64'(write_out), 64'(exp_wo));
    end
  end

  always @(negedge clk) if (stall === 1'b1) stall_seen++;

  function automatic logic [IO_CH*DATA_W-1:0] pack_wo();
    logic [IO_CH*DATA_W-1:0] p;
    for (int i = 0; i < int'(IO_CH); i++) p[i*DATA_W +: DATA_W] = m_wo[i];
    return p;
  endfunction

  function automatic bit is_io(input logic [15:0] a);
    return a[15:4] == 12'hFFF;
  endfunction

  task automatic scramble();
    valid_in = 1'($urandom);
    memread  = 1'($urandom);
    memwrite = 1'($urandom);
    aluout   = 16'($urandom);
    b        = 16'($urandom);
    read_in  = 32'($urandom);
  endtask

  // Effect of one completed instruction, straight from the access rules.
  task automatic apply_op(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input logic [31:0] rin);
    int ch;
    ch = int'(a[3:0]);
    exp_valid  = 1'b1;
    exp_alufor = a;
    exp_strobe = '0;
    if (wr) begin
      if (is_io(a)) begin
        if (ch < int'(IO_CH)) begin
          m_wo[ch] = d;
          exp_strobe[ch] = 1'b1;
        end
`ifdef MEM_STAGE_PERF_EN
        if (ch == 14) m_acc = 0;
        if (ch == 15) m_stl = 0;
`endif
      end else begin
        m_mem[a[9:0]] = d;
`ifdef MEM_STAGE_PERF_EN
        if (m_acc < 65535) m_acc++;
`endif
      end
    end else if (rd) begin
      if (is_io(a)) begin
        if (ch < int'(IO_CH)) exp_memout = rin[ch*16 +: 16];
        else exp_memout = '0;
`ifdef MEM_STAGE_PERF_EN
        if (ch == 14) exp_memout = 16'(m_acc);
        if (ch == 15) exp_memout = 16'(m_stl);
`endif
      end else begin
        exp_memout = m_mem[a[9:0]];
`ifdef MEM_STAGE_PERF_EN
        if (m_acc < 65535) m_acc++;
`endif
      end
    end
    exp_wo = pack_wo();
  endtask

  // Present one instruction at posedge+1 and run it to completion; WAIT cycles get garbage inputs.
  task automatic issue(input logic vld, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d, input logic [31:0] rin);
    int n;
    valid_in = vld; memread = rd; memwrite = wr; aluout = a; b = d; read_in = rin;
    if (!vld) begin
      exp_stall = 1'b0;
      @(posedge clk); #1;
      exp_valid = 1'b0;
      exp_strobe = '0;
      return;
    end
    n = ((rd || wr) && !is_io(a)) ? int'(WS) : 0;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        exp_valid = 1'b0;
        exp_strobe = '0;
        scramble();
      end
      exp_stall = (k < n);
      @(posedge clk); #1;
    end
`ifdef MEM_STAGE_PERF_EN
    m_stl = (m_stl + n > 65535) ? 65535 : m_stl + n;
`endif
    apply_op(rd, wr, a, d, rin);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    exp_stall = 1'b0; exp_valid = 1'b0; exp_strobe = '0;
    exp_memout = '0; exp_alufor = '0;
    for (int i = 0; i < int'(IO_CH); i++) m_wo[i] = '0;
    exp_wo = '0;
`ifdef MEM_STAGE_PERF_EN
    m_acc = 0;
    m_stl = 0;
`endif
    for (int i = 0; i < cycles; i++) begin
      scramble();
      @(posedge clk); #1;
    end
    rst = 1'b1;
    valid_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] wo_save;
    logic [15:0] mo_save;
    logic [31:0] r;
    logic        vld, rd, wr;
    logic [15:0] a;

    exp_stall = 1'b0; exp_valid = 1'b0; exp_strobe = '0;
    exp_memout = '0; exp_alufor = '0; exp_wo = '0;
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    do_reset(3);
    chk("rst_memout", 64'(memout), 64'h0);
    chk("rst_alufor", 64'(alufor), 64'h0);
    chk("rst_write_out", 64'(write_out), 64'h0);
    chk("rst_valid", 64'(valid_out), 64'h0);

    stall_seen = 0;
    issue(1, 0, 1, 16'h0010, 16'hBEEF, 32'($urandom));
    chk("first_op_stall_cycles", 64'(stall_seen), 64'd2);
    chk("first_op_valid", 64'(valid_out), 64'h1);
    issue(1, 0, 1, 16'h0020, 16'h5555, 32'($urandom));
    for (int i = 0; i < 16; i++)
      issue(1, 0, 1, {6'($urandom), 6'b0, 4'(i)}, 16'($urandom), 32'($urandom));

    issue(1, 1, 0, 16'h0010, 16'($urandom), 32'($urandom));
    chk("load_0010", 64'(memout), 64'hBEEF);
    issue(1, 1, 0, 16'h0410, 16'($urandom), 32'($urandom));
    chk("load_alias_0410", 64'(memout), 64'hBEEF);

    issue(1, 0, 1, 16'hFFF1, 16'h1234, 32'($urandom));
    chk("io_wr_ch1", 64'(write_out[31:16]), 64'h1234);
    chk("io_strobe_ch1", 64'(write_strobe), 64'h2);
    issue(0, 1, 1, 16'($urandom), 16'($urandom), 32'($urandom));
    chk("io_strobe_clear", 64'(write_strobe), 64'h0);
    issue(1, 1, 0, 16'hFFF0, 16'($urandom), {16'($urandom), 16'h00A5});
    chk("io_rd_ch0", 64'(memout), 64'h00A5);
    wo_save = write_out;
    issue(1, 0, 1, 16'hFFF5, 16'hDEAD, 32'($urandom));
    chk("io_wr_ch5_strobe", 64'(write_strobe), 64'h0);
    chk("io_wr_ch5_out", 64'(write_out), 64'(wo_save));

    mo_save = memout;
    issue(1, 0, 0, 16'h0042, 16'($urandom), 32'($urandom));
    chk("nonmem_alufor", 64'(alufor), 64'h0042);
    chk("nonmem_memout", 64'(memout), 64'(mo_save));
    issue(1, 1, 1, 16'h0003, 16'hA5A5, 32'($urandom));
    chk("rdwr_memout_hold", 64'(memout), 64'(mo_save));

    // Reset while the store to 0x0020 is waiting must drop it.
    valid_in = 1'b1; memread = 1'b0; memwrite = 1'b1; aluout = 16'h0020; b = 16'h7777;
    exp_stall = 1'b1;
    @(posedge clk); #1;
    do_reset(2);
    issue(1, 1, 0, 16'h0020, 16'($urandom), 32'($urandom));
    chk("abort_load_0020", 64'(memout), 64'h5555);

`ifdef MEM_STAGE_PERF_EN
    issue(1, 0, 1, 16'h0001, 16'h1111, 32'($urandom));
    issue(1, 1, 0, 16'h0001, 16'h0, 32'($urandom));
    issue(1, 0, 1, 16'h0002, 16'h2222, 32'($urandom));
    issue(1, 1, 0, 16'hFFFE, 16'h0, 32'($urandom));
    chk("perf_acc_3", 64'(memout), 64'd3);
    issue(1, 1, 0, 16'hFFFF, 16'h0, 32'($urandom));
    chk("perf_stall_6", 64'(memout), 64'd6);
    issue(1, 0, 1, 16'hFFFE, 16'h0, 32'($urandom));
    issue(1, 1, 0, 16'hFFFE, 16'h0, 32'($urandom));
    chk("perf_acc_clr", 64'(memout), 64'd0);
`else
    issue(1, 1, 0, 16'hFFFE, 16'h0, 32'($urandom));
    chk("io_rd_ch14_zero", 64'(memout), 64'd0);
`endif

    for (int it = 0; it < 800; it++) begin
      r   = $urandom;
      vld = 1'b1;
      rd  = r[4];
      wr  = r[5];
      case (r[1:0])
        2'd0:    a = {6'($urandom), 6'b0, 4'($urandom)};
        2'd1:    a = {12'hFFF, 4'($urandom)};
        2'd2:    begin rd = 1'b0; wr = 1'b0; a = 16'($urandom); end
        default: begin vld = 1'b0; a = 16'($urandom); end
      endcase
      issue(vld, rd, wr, a, 16'($urandom), 32'($urandom));
    end
    issue(0, 0, 0, 16'h0, 16'h0, 32'h0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
